display_source_arbiter: RTL and testbench
=========================================

// Module: display_source_arbiter
// PURPOSE
//  Chooses which requester owns the 6-digit 74HC595 LED display, and drives the scan driver's BCD digit inputs.
//  Requesters, by priority: alert (timed, latched) > edit/set mode > free-running time (default).
//  Also generates blink masking: edited digit pair blinks; whole display flashes while an alert is shown.
//  Sits between the clock/stopwatch/alarm logic and the display scan driver.
// PARAMETERS
//  CLK_HZ         12_000_000  clk_in frequency; ms tick = CLK_HZ/1000 clocks (must be integer, >=2)
//  BLINK_HALF_MS  250         blink half-period in ms (visible phase = blank phase = this), >=1
//  HOLD_MS        3000        alert display duration in ms after last alert_trig, >=1
// PORTS
//  clk_in         in   1   system clock
//  rst_n_in       in   1   asynchronous, active-low reset
//  time_digits    in   24  {hour_shi,hour_ge,min_shi,min_ge,sec_shi,sec_ge}, BCD, from clock core
//  edit_req       in   1   level: set mode active
//  edit_digits    in   24  digits under edit, same packing
//  edit_pos       in   3   0=hours pair,1=minutes pair,2=seconds pair, other=no blink
//  alert_trig     in   1   1-cycle pulse: start/restart alert display
//  alert_ack      in   1   1-cycle pulse: dismiss alert
//  alert_digits   in   24  digits shown during alert, same packing
//  hour_shi..sec_ge out 4 each (6 ports)  registered digits to scan driver; 4'd10 = blank
//  active_src     out  2   0=time,1=edit,2=alert (registered, tracks state)
//  alert_active   out  1   high while in S_ALERT
// BEHAVIOUR
//  Reset: state S_TIME, all six digit outputs 4'd10, active_src 0, alert_active 0, blink_phase 1 (visible),
//   ms prescaler/blink/hold counters 0. Reset asserted mid-alert discards the alert.
//  ms_tick: 1-cycle pulse every CLK_HZ/1000 clocks, free-running from reset.
//  FSM (priority evaluated each cycle, next-state registered):
//   any state, alert_trig=1      -> S_ALERT, hold_cnt <= HOLD_MS-1, blink_phase <= 1, blink_cnt <= 0
//   S_ALERT, alert_ack=1 (no trig) or (ms_tick && hold_cnt==0) -> S_EDIT if edit_req else S_TIME
//   S_ALERT, ms_tick, hold_cnt>0 -> hold_cnt-1; alert_trig+alert_ack same cycle: trig wins (restart)
//   S_TIME,  edit_req=1          -> S_EDIT, blink_phase <= 1, blink_cnt <= 0
//   S_EDIT,  edit_req=0          -> S_TIME
//   alert_ack outside S_ALERT: ignored.
//  Blink: on ms_tick blink_cnt increments; at BLINK_HALF_MS-1 it wraps to 0 and blink_phase toggles.
//   edit_pos change while in S_EDIT restarts blink: phase 1, cnt 0 (new field visible at once).
//  Digit mux (combinational from state/inputs, then one register stage => 1-cycle latency):
//   S_TIME : time_digits. S_EDIT: edit_digits, selected pair forced to 4'd10 when blink_phase=0.
//   S_ALERT: alert_digits when blink_phase=1, all six = 4'd10 when blink_phase=0.
//   Sanitize: any selected nibble >9 output as 4'd10 (driver glyph table has only 0..10).
//  active_src/alert_active update in the same cycle as digits (consistent with each other).
//  Counter widths: prescaler clog2(CLK_HZ/1000); blink clog2(BLINK_HALF_MS); hold clog2(HOLD_MS); no overflow.
// STRUCTURE
//  display_pkg: state codes S_TIME=2'd0,S_EDIT=2'd1,S_ALERT=2'd2; SRC_* ids; BLANK_DIGIT=4'd10;
//   digit-field offsets for the 24-bit packing.
//  Sub-module ms_tick_gen (param CLK_HZ; clk_in,rst_n_in -> tick): reused by clock core.
//  Top: FSM + hold/blink counters + output mux/register, one always block per register group.
// TESTING  (sim with CLK_HZ=4000 => 4 clk/ms, BLINK_HALF_MS=2, HOLD_MS=5)
//  1 Reset, time_digits=24'h123456 -> 1 clk after release outputs 1,2,3,4,5,6; active_src=0.
//  2 edit_req=1, edit_digits=24'h085900, edit_pos=1 -> min pair shows 5,9 for 8 clk then 10,10
//    for 8 clk, repeating; hour/sec pairs steady 0,8 / 0,0; active_src=1.
//  3 alert_trig pulse, alert_digits=24'h070000 -> all digits flash 0,7,0,0,0,0 / blank at 8-clk phases;
//    returns to time after exactly 5 ms (20 clk +-1 tick alignment); alert_active falls same cycle.
//  4 alert_trig at ms 3 of alert -> hold restarts, total alert 8 ms; trig+ack same cycle -> alert stays.
//  5 edit_req high during alert, alert_ack -> next state S_EDIT, active_src=1, edited pair visible.
//  6 time_digits=24'hAF3456 -> outputs 10,10,3,4,5,6; rst_n_in low mid-alert -> all 4'd10, S_TIME.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display source arbiter and its neighbours.
//   state_t        arbiter FSM state codes
//   SRC_*          source ids reported on active_src
//   BLANK_DIGIT    glyph code the scan driver renders as an unlit digit
//   *_LSB          nibble offsets inside the 24-bit packed digit word
//                  {hour_shi,hour_ge,min_shi,min_ge,sec_shi,sec_ge}
//   sanitize_digits / blank_pair   helpers for the output digit mux
package display_pkg;

  typedef enum logic [1:0] {
    S_TIME  = 2'd0,
    S_EDIT  = 2'd1,
    S_ALERT = 2'd2
  } state_t;

  localparam logic [1:0] SRC_TIME  = 2'd0;
  localparam logic [1:0] SRC_EDIT  = 2'd1;
  localparam logic [1:0] SRC_ALERT = 2'd2;

  localparam logic [3:0] BLANK_DIGIT = 4'd10;
  localparam int         NUM_DIGITS  = 6;
  localparam logic [23:0] ALL_BLANK  = {NUM_DIGITS{BLANK_DIGIT}};

  localparam int HOUR_SHI_LSB = 20;
  localparam int HOUR_GE_LSB  = 16;
  localparam int MIN_SHI_LSB  = 12;
  localparam int MIN_GE_LSB   = 8;
  localparam int SEC_SHI_LSB  = 4;
  localparam int SEC_GE_LSB   = 0;

  // The driver glyph table only covers 0..10, so any nibble above 9
  // is shown as a blank digit rather than an undefined pattern.
  function automatic logic [23:0] sanitize_digits(input logic [23:0] d);
    logic [23:0] r;
    r = d;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (d[i*4 +: 4] > 4'd9) r[i*4 +: 4] = BLANK_DIGIT;
    end
    return r;
  endfunction

  // Blank the digit pair selected by pos; positions 3..7 leave all digits lit.
  function automatic logic [23:0] blank_pair(input logic [23:0] d,
                                             input logic [2:0]  pos);
    logic [23:0] r;
    r = d;
    case (pos)
      3'd0:    r[HOUR_GE_LSB +: 8] = {2{BLANK_DIGIT}};
      3'd1:    r[MIN_GE_LSB  +: 8] = {2{BLANK_DIGIT}};
      3'd2:    r[SEC_GE_LSB  +: 8] = {2{BLANK_DIGIT}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/display_source_arbiter_ms_tick_gen.sv
// Millisecond tick generator, shared with the clock core.
//   clk_in    system clock (CLK_HZ)
//   rst_n_in  asynchronous active-low reset
//   tick      one-clock pulse every CLK_HZ/1000 clocks, free-running
module ms_tick_gen #(
  parameter int CLK_HZ = 12_000_000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  output logic tick
);

  localparam int DIV   = CLK_HZ / 1000;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/display_source_arbiter.sv
// Chooses which requester owns the 6-digit LED display and drives the scan
// driver's BCD digit inputs. Priority: alert > edit > free-running time.
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   time_digits[23:0]       packed BCD time from the clock core
//   edit_req, edit_digits   set-mode level and the digits under edit
//   edit_pos[2:0]           0=hours,1=minutes,2=seconds pair blinks; else none
//   alert_trig, alert_ack   one-cycle pulses: start/restart, dismiss alert
//   alert_digits[23:0]      digits shown while the alert is displayed
//   hour_shi..sec_ge        registered digits to the scan driver (10 = blank)
//   active_src[1:0]         0=time,1=edit,2=alert, registered with the digits
//   alert_active            high while the alert is on the display
// Every input is sampled on each clk_in edge; there is no back-pressure.
// The digit mux reads the current state, so outputs lag a state change by
// exactly one clock, and active_src/alert_active lag identically.
module display_source_arbiter
  import display_pkg::*;
#(
  parameter int CLK_HZ        = 12_000_000,
  parameter int BLINK_HALF_MS = 250,
  parameter int HOLD_MS       = 3000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [23:0] time_digits,
  input  logic        edit_req,
  input  logic [23:0] edit_digits,
  input  logic [2:0]  edit_pos,
  input  logic        alert_trig,
  input  logic        alert_ack,
  input  logic [23:0] alert_digits,
  output logic [3:0]  hour_shi,
  output logic [3:0]  hour_ge,
  output logic [3:0]  min_shi,
  output logic [3:0]  min_ge,
  output logic [3:0]  sec_shi,
  output logic [3:0]  sec_ge,
  output logic [1:0]  active_src,
  output logic        alert_active
);

  localparam int BLINK_W = (BLINK_HALF_MS > 1) ? $clog2(BLINK_HALF_MS) : 1;
  localparam int HOLD_W  = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_MS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_MS - 1);

  state_t             state;
  logic               ms_tick;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [2:0]         edit_pos_q;
  logic [23:0]        digits_q;
  logic [23:0]        mux_digits;
  logic [1:0]         mux_src;

  logic alert_done;
  logic enter_edit;
  logic pos_moved;
  logic blink_restart;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .tick     (ms_tick)
  );

  // Alert leaves on ack or when the hold time has fully elapsed; a trig in
  // the same cycle overrides both (handled by the FSM priority below).
  assign alert_done = (state == S_ALERT) &&
                      (alert_ack || (ms_tick && (hold_cnt == '0)));

  // Every entry into edit mode (from time, or from a dismissed alert) starts
  // a fresh visible blink phase so the field under edit is seen at once.
  assign enter_edit = !alert_trig && edit_req &&
                      ((state == S_TIME) || alert_done);
  assign pos_moved  = (state == S_EDIT) && (edit_pos != edit_pos_q);
  assign blink_restart = alert_trig || enter_edit || pos_moved;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_TIME;
    end else if (alert_trig) begin
      state <= S_ALERT;
    end else begin
      case (state)
        S_TIME:  if (edit_req)   state <= S_EDIT;
        S_EDIT:  if (!edit_req)  state <= S_TIME;
        S_ALERT: if (alert_done) state <= edit_req ? S_EDIT : S_TIME;
        default: state <= S_TIME;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hold_cnt <= '0;
    end else if (alert_trig) begin
      hold_cnt <= HOLD_LOAD;
    end else if ((state == S_ALERT) && ms_tick && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_restart) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (ms_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      edit_pos_q <= 3'd0;
    end else begin
      edit_pos_q <= edit_pos;
    end
  end

  always_comb begin
    mux_digits = sanitize_digits(time_digits);
    mux_src    = SRC_TIME;
    case (state)
      S_EDIT: begin
        mux_src    = SRC_EDIT;
        mux_digits = sanitize_digits(edit_digits);
        if (!blink_phase) mux_digits = blank_pair(mux_digits, edit_pos);
      end
      S_ALERT: begin
        mux_src    = SRC_ALERT;
        mux_digits = blink_phase ? sanitize_digits(alert_digits) : ALL_BLANK;
      end
      default: begin
        mux_src    = SRC_TIME;
        mux_digits = sanitize_digits(time_digits);
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      digits_q     <= ALL_BLANK;
      active_src   <= SRC_TIME;
      alert_active <= 1'b0;
    end else begin
      digits_q     <= mux_digits;
      active_src   <= mux_src;
      alert_active <= (state == S_ALERT);
    end
  end

  assign hour_shi = digits_q[HOUR_SHI_LSB +: 4];
  assign hour_ge  = digits_q[HOUR_GE_LSB  +: 4];
  assign min_shi  = digits_q[MIN_SHI_LSB  +: 4];
  assign min_ge   = digits_q[MIN_GE_LSB   +: 4];
  assign sec_shi  = digits_q[SEC_SHI_LSB  +: 4];
  assign sec_ge   = digits_q[SEC_GE_LSB   +: 4];

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter with a 4-clock millisecond,
// 2 ms blink half-period and 5 ms alert hold. Expected words are
// {alert_active, active_src, six digits}. Where the millisecond phase is
// not pinned down, checks sit at cycle offsets that hold for any tick
// alignment, and the alert exit is accepted within its one-tick window.
module tb_display_source_arbiter;

  localparam int CLK_HZ        = 4000;
  localparam int BLINK_HALF_MS = 2;
  localparam int HOLD_MS       = 5;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [23:0] time_digits;
  logic        edit_req;
  logic [23:0] edit_digits;
  logic [2:0]  edit_pos;
  logic        alert_trig;
  logic        alert_ack;
  logic [23:0] alert_digits;
  logic [3:0]  hour_shi, hour_ge, min_shi, min_ge, sec_shi, sec_ge;
  logic [1:0]  active_src;
  logic        alert_active;

  display_source_arbiter #(
    .CLK_HZ        (CLK_HZ),
    .BLINK_HALF_MS (BLINK_HALF_MS),
    .HOLD_MS       (HOLD_MS)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .time_digits  (time_digits),
    .edit_req     (edit_req),
    .edit_digits  (edit_digits),
    .edit_pos     (edit_pos),
    .alert_trig   (alert_trig),
    .alert_ack    (alert_ack),
    .alert_digits (alert_digits),
    .hour_shi     (hour_shi),
    .hour_ge      (hour_ge),
    .min_shi      (min_shi),
    .min_ge       (min_ge),
    .sec_shi      (sec_shi),
    .sec_ge       (sec_ge),
    .active_src   (active_src),
    .alert_active (alert_active)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [26:0] exp_q[$];
  string       tag_q[$];
  int          compared   = 0;
  int          mismatched = 0;

  function automatic logic [26:0] pack_exp(input logic a, input logic [1:0] s,
                                           input logic [23:0] d);
    return {a, s, d};
  endfunction

  function automatic logic [26:0] observed();
    return {alert_active, active_src, hour_shi, hour_ge, min_shi, min_ge,
            sec_shi, sec_ge};
  endfunction

  task automatic check_head();
    logic [26:0] exp_w;
    logic [26:0] obs_w;
    string       tag;
    exp_w = exp_q.pop_front();
    tag   = tag_q.pop_front();
    obs_w = observed();
    compared++;
    assert (obs_w === exp_w) else begin
      mismatched++;
      $error("FAIL %s: got alert=%b src=%0d digits=%h, want alert=%b src=%0d digits=%h",
             tag, obs_w[26], obs_w[25:24], obs_w[23:0],
             exp_w[26], exp_w[25:24], exp_w[23:0]);
    end
  endtask

  // Queue the expectation now, then compare once the output of posedge
  // number 'target' is visible (sampled on the following negedge).
  task automatic sample_at(input int target, input string tag,
                           input logic [26:0] exp_w);
    exp_q.push_back(exp_w);
    tag_q.push_back(tag);
    while (cyc < target) @(negedge clk_in);
    check_head();
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk_in);
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic trig, input logic ack);
    alert_trig = trig;
    alert_ack  = ack;
    @(negedge clk_in);
    alert_trig = 1'b0;
    alert_ack  = 1'b0;
  endtask

  // Alert (started/restarted at posedge a) must drop 18..21 clocks later,
  // together with the source and digits switching to the fallback source.
  task automatic wait_alert_fall(input int a, input string tag,
                                 input logic [1:0] src, input logic [23:0] d);
    while (alert_active === 1'b1 && cyc < a + 40) @(negedge clk_in);
    compared++;
    assert ((alert_active === 1'b0 && cyc >= a + 18 && cyc <= a + 21) === 1'b1) else begin
      mismatched++;
      $error("FAIL %s: alert_active=%b first low at offset %0d, want low first at offset 18..21",
             tag, alert_active, cyc - a);
    end
    sample_at(cyc, {tag, "_out"}, pack_exp(1'b0, src, d));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e, c2, f, g, h, p, a, a2, a3, k;

    rst_n_in     = 1'b1;
    time_digits  = 24'h123456;
    edit_req     = 1'b0;
    edit_digits  = 24'h085900;
    edit_pos     = 3'd1;
    alert_trig   = 1'b0;
    alert_ack    = 1'b0;
    alert_digits = 24'h070000;
    #2 rst_n_in  = 1'b0;

    // 1: reset state, then time digits one clock after release
    repeat (3) @(negedge clk_in);
    sample_at(cyc, "reset_state", pack_exp(1'b0, 2'd0, 24'hAAAAAA));
    rst_n_in = 1'b1;
    e = cyc + 1;
    sample_at(e, "time_after_reset", pack_exp(1'b0, 2'd0, 24'h123456));

    // 2: edit mode, minutes pair blinks with 8-clock phases
    wait_to(e + 4);
    edit_req = 1'b1;
    e = cyc + 1;
    sample_at(e + 1,  "edit_vis0",  pack_exp(1'b0, 2'd1, 24'h085900));
    sample_at(e + 4,  "edit_vis1",  pack_exp(1'b0, 2'd1, 24'h085900));
    sample_at(e + 11, "edit_blank", pack_exp(1'b0, 2'd1, 24'h08AA00));
    sample_at(e + 19, "edit_vis2",  pack_exp(1'b0, 2'd1, 24'h085900));
    sample_at(e + 26, "edit_blank2", pack_exp(1'b0, 2'd1, 24'h08AA00));

    // edit_pos change during the blank phase restarts the blink visible
    edit_pos = 3'd2;
    c2 = cyc + 1;
    sample_at(c2,      "pos_new_blank",  pack_exp(1'b0, 2'd1, 24'h0859AA));
    sample_at(c2 + 1,  "pos_change_vis", pack_exp(1'b0, 2'd1, 24'h085900));
    sample_at(c2 + 11, "sec_blank",      pack_exp(1'b0, 2'd1, 24'h0859AA));

    edit_pos = 3'd3;
    f = cyc + 1;
    sample_at(f + 11, "pos3_noblink", pack_exp(1'b0, 2'd1, 24'h085900));
    edit_digits = 24'h0859F0;
    g = cyc;
    sample_at(g + 1, "edit_sanitize", pack_exp(1'b0, 2'd1, 24'h0859A0));

    edit_req    = 1'b0;
    edit_digits = 24'h085900;
    edit_pos    = 3'd1;
    h = cyc;
    sample_at(h + 2, "edit_to_time", pack_exp(1'b0, 2'd0, 24'h123456));
    pulse(1'b0, 1'b1);
    p = cyc;
    sample_at(p + 2, "ack_ignored", pack_exp(1'b0, 2'd0, 24'h123456));

    // 3: alert flashes and times out after 5 ms
    pulse(1'b1, 1'b0);
    a = cyc;
    sample_at(a + 1,  "alert_vis0",  pack_exp(1'b1, 2'd2, 24'h070000));
    sample_at(a + 11, "alert_blank", pack_exp(1'b1, 2'd2, 24'hAAAAAA));
    sample_at(a + 17, "alert_vis1",  pack_exp(1'b1, 2'd2, 24'h070000));
    wait_alert_fall(a, "alert_timeout", 2'd0, 24'h123456);

    // 4: retrigger at ms 3 restarts the hold
    pulse(1'b1, 1'b0);
    a = cyc;
    wait_to(a + 11);
    pulse(1'b1, 1'b0);
    a2 = cyc;
    sample_at(a2 + 17, "retrig_hold", pack_exp(1'b1, 2'd2, 24'h070000));
    wait_alert_fall(a2, "retrig_timeout", 2'd0, 24'h123456);

    // trig and ack in the same cycle: trig wins
    pulse(1'b1, 1'b0);
    a = cyc;
    wait_to(a + 3);
    pulse(1'b1, 1'b1);
    a3 = cyc;
    sample_at(a3 + 1,  "trig_ack_stay", pack_exp(1'b1, 2'd2, 24'h070000));
    sample_at(a3 + 17, "trig_ack_hold", pack_exp(1'b1, 2'd2, 24'h070000));
    wait_alert_fall(a3, "trig_ack_timeout", 2'd0, 24'h123456);

    // 5: ack with edit_req high returns to edit, edited pair visible
    edit_req = 1'b1;
    @(negedge clk_in);
    pulse(1'b1, 1'b0);
    a = cyc;
    wait_to(a + 10);
    pulse(1'b0, 1'b1);
    k = cyc;
    sample_at(k + 1, "ack_to_edit", pack_exp(1'b0, 2'd1, 24'h085900));
    edit_req = 1'b0;
    h = cyc;
    sample_at(h + 2, "edit_exit", pack_exp(1'b0, 2'd0, 24'h123456));

    // 6: out-of-range nibbles blank; reset mid-alert discards the alert
    time_digits = 24'hAF3456;
    g = cyc;
    sample_at(g + 1, "time_sanitize", pack_exp(1'b0, 2'd0, 24'hAA3456));
    pulse(1'b1, 1'b0);
    a = cyc;
    sample_at(a + 1, "alert_before_reset", pack_exp(1'b1, 2'd2, 24'h070000));
    wait_to(a + 5);
    rst_n_in = 1'b0;
    #1;
    sample_at(cyc, "reset_mid_alert", pack_exp(1'b0, 2'd0, 24'hAAAAAA));
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    e = cyc + 1;
    sample_at(e,      "time_after_reset2", pack_exp(1'b0, 2'd0, 24'hAA3456));
    sample_at(e + 25, "alert_discarded",   pack_exp(1'b0, 2'd0, 24'hAA3456));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
